// File: rtl/fpu_result_arbiter_pkg.sv
// Shared FPU definitions: exception flag layout, execution unit indices and
// the round-robin pick helper used by the result arbiter.
package fpu_result_arbiter_pkg;

    localparam int FPU_FLAG_W = 5;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [1:0] UNIT_ADD = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd2;
    localparam logic [1:0] UNIT_CVT = 2'd3;

    // Scan starts just after the last winner and wraps back to it last, so
    // the previous winner is only picked again when nobody else is waiting.
    function automatic logic [1:0] rrPick(input logic [3:0] valid,
                                          input logic [1:0] lastGrant);
        logic [1:0] pick;
        logic       found;
        logic [1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = lastGrant + 2'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fpu_result_arbiter_mux4.sv
// Generic 4:1 multiplexer; the arbiter feeds it {data, flags} per unit.
module mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        unique case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end

endmodule

// File: rtl/fpu_result_arbiter.sv
// Round-robin arbiter that funnels results from the four FPU execution units
// into a single registered writeback stage with valid/ready handshake.
module fpu_result_arbiter
    import fpu_result_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FLAG_W = FPU_FLAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    input  logic [WIDTH-1:0]  in0_data,
    input  logic [WIDTH-1:0]  in1_data,
    input  logic [WIDTH-1:0]  in2_data,
    input  logic [WIDTH-1:0]  in3_data,
    input  logic [FLAG_W-1:0] in0_flags,
    input  logic [FLAG_W-1:0] in1_flags,
    input  logic [FLAG_W-1:0] in2_flags,
    input  logic [FLAG_W-1:0] in3_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [1:0]        out_src
);

    localparam int MW = WIDTH + FLAG_W;

    logic              validQ, validD;
    logic [WIDTH-1:0]  dataQ, dataD;
    logic [FLAG_W-1:0] flagsQ, flagsD;
    logic [1:0]        srcQ, srcD;
    logic [1:0]        lastGrantQ, lastGrantD;

    logic              load;
    logic              anyValid;
    logic              take;
    logic [1:0]        gidx;
    logic [MW-1:0]     muxOut;

    mux4 #(.WIDTH(MW)) uMux (
        .in0 ({in0_data, in0_flags}),
        .in1 ({in1_data, in1_flags}),
        .in2 ({in2_data, in2_flags}),
        .in3 ({in3_data, in3_flags}),
        .sel (gidx),
        .y   (muxOut)
    );

    // The output slot can accept whenever it is empty or being drained this cycle.
    always_comb begin
        anyValid = |in_valid;
        load     = !validQ || out_ready;
        gidx     = rrPick(in_valid, lastGrantQ);
        take     = load && anyValid;
        in_ready = (take && rst_n) ? (4'b0001 << gidx) : 4'b0000;
    end

    always_comb begin
        validD     = validQ;
        dataD      = dataQ;
        flagsD     = flagsQ;
        srcD       = srcQ;
        lastGrantD = lastGrantQ;
        if (take) begin
            validD     = 1'b1;
            dataD      = muxOut[MW-1:FLAG_W];
            flagsD     = muxOut[FLAG_W-1:0];
            srcD       = gidx;
            lastGrantD = gidx;
        end else if (validQ && out_ready) begin
            validD = 1'b0;
        end
    end

    // Pointer resets to unit 3 so that unit 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validQ     <= 1'b0;
            dataQ      <= '0;
            flagsQ     <= '0;
            srcQ       <= 2'd0;
            lastGrantQ <= 2'd3;
        end else begin
            validQ     <= validD;
            dataQ      <= dataD;
            flagsQ     <= flagsD;
            srcQ       <= srcD;
            lastGrantQ <= lastGrantD;
        end
    end

    assign out_valid = validQ;
    assign out_data  = dataQ;
    assign out_flags = flagsQ;
    assign out_src   = srcQ;

endmodule

// File: doc/fpu_result_arbiter.md
Name: fpu_result_arbiter

Overview:
- Collects completed results from four FPU execution units (add/sub, mul, div, convert) and passes them one at a time to the writeback port.
- Round-robin arbitration; the winner's index drives the select of a 4:1 result multiplexer.
- The selected result, flags and source tag are registered in a one-entry output stage with valid/ready handshake.
- Sits directly downstream of the execution units and directly upstream of writeback.

Parameters:
- WIDTH, 32, result data width in bits.
- FLAG_W, 5, IEEE-754 exception flag width (NV, DZ, OF, UF, NX).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  4  per-unit result valid; bit i belongs to unit i.
- in_ready  output  4  per-unit accept; a transfer occurs on unit i when in_valid[i] and in_ready[i] are both high.
- in0_data .. in3_data  input  WIDTH  result data of units 0..3.
- in0_flags .. in3_flags  input  FLAG_W  exception flags of units 0..3.
- out_valid  output  1  registered result valid.
- out_ready  input  1  writeback accepts the registered result.
- out_data  output  WIDTH  registered result data.
- out_flags  output  FLAG_W  registered flags.
- out_src  output  2  index of the unit that produced out_data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, out_flags=0, out_src=0.
  - Priority pointer last_grant=3, so unit 0 has first priority.
  - in_ready=0 while rst_n is low.
  - Reset mid-operation discards any held result; no partial state survives.
- Load enable: load = !out_valid || out_ready. This is combinational and gives full throughput of one result per cycle.
- Arbitration (combinational, evaluated every cycle):
  - Candidate order is last_grant+1, +2, +3, +4, modulo 4 (2-bit wrap-around).
  - The first i in that order with in_valid[i]=1 wins; its index is gidx.
  - in_ready[i] = load && any_valid && (i==gidx). At most one bit is high.
- Transfer (clock edge with load && any_valid):
  - out_data and out_flags take unit gidx's data and flags through the mux with sel=gidx.
  - out_src=gidx, out_valid=1, last_grant=gidx.
  - Latency from input handshake to out_valid: 1 cycle.
- Drain: at an edge with out_valid && out_ready && !any_valid, out_valid=0. Data, flags and src hold their last values.
- Stall: if out_valid && !out_ready, then load=0, all in_ready=0, and all output registers and last_grant hold.
- Simultaneous drain and new grant in the same cycle: the output is overwritten with the new result and out_valid stays 1 (no bubble).
- Idle (no in_valid): last_grant does not change.
- Input rules:
  - A unit must hold in_valid, data and flags stable until it is accepted.
  - in_ready may depend combinationally on in_valid. Units must not make in_valid depend on in_ready.
- Fairness: with all four units continuously valid, grants rotate 0,1,2,3,0,…
  - No unit waits more than 3 accepted transfers once it is valid.

Decomposition:
- Shared FPU package:
  - FLAG_W and the flag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0).
  - Unit index constants: UNIT_ADD=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_CVT=3.
- Sub-module: the existing parameterised mux4, instantiated once with WIDTH = WIDTH+FLAG_W.
  - Data and flags are concatenated on each input.
  - sel is driven by gidx.
- Arbiter logic, pointer and output register stay in this module.

Test Plan:
- Reset, then in_valid=4'b0001, in0_data=32'h3F800000, flags=0, out_ready=1 → next cycle: out_valid=1, out_data=32'h3F800000, out_src=0, in_ready was 4'b0001.
- All four valid continuously, in_i_data=i+1, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles; out_data sequence 1,2,3,4,1.
- out_ready=0 with out_valid=1 and unit 2 valid → in_ready=0 every cycle and outputs stable. Release out_ready → unit 2 is accepted in the same cycle; next cycle out_src=2.
- Unit 1 valid only, after last_grant=1 → unit 1 is still granted (wrap to self); flags=5'b00001 reproduced on out_flags.
- Assert rst_n=0 for one cycle while out_valid=1 → next cycle out_valid=0, out_data=0, and unit 0 has first priority when all are valid.
- Single result followed by no valid inputs with out_ready=1 → out_valid drops after one cycle, out_data holds its last value.
